uart_rx_oversample: RTL and testbench
=====================================

# uart_rx_oversample

Oversampling UART receiver that turns the serial line driven by the bridge (or a host adapter) back into bytes for on-chip logic. It synchronises the asynchronous `rx` input, detects start bits, samples each bit at its centre using a configurable oversampling tick, and presents each received byte on a valid/ready interface. It is the serial-to-parallel end of the UART link and runs from the 100 MHz system clock.

## Interface
- `CLK_FREQ`, 100_000_000, system clock frequency in Hz.
- `BAUD_RATE`, 115200, line rate in bit/s.
- `OVERSAMPLE`, 16, ticks per bit. Must be even and ≥ 4.
- `clk`  input  1  system clock. All logic is on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `rx`  input  1  asynchronous serial line, idle high.
- `data`  output  8  received byte. Valid while `valid`=1.
- `valid`  output  1  byte available.
- `ready`  input  1  consumer accepts the byte on `valid && ready`.
- `busy`  output  1  high while a frame is being received (any state other than IDLE).
- `frame_err`  output  1  one-cycle pulse when the stop bit is sampled low.
- `overrun`  output  1  one-cycle pulse when a completed byte is dropped.
- `parity_err`  output  1  present only with `UART_RX_PARITY_EN`; one-cycle pulse.

## Operation
- **Input synchroniser.** `rx` passes through a 2-flop synchroniser; both flops reset to 1. The synchronised signal is `rx_s`.
- **Tick generator.**
  - `DIV = CLK_FREQ / (BAUD_RATE*OVERSAMPLE)`, using integer truncation. With the defaults, DIV = 54.
  - The counter counts 0..DIV-1 and emits a one-cycle `tick` at DIV-1.
  - It is held at 0 in IDLE, so phase is aligned to the start edge.
- **Armed flag.** It is set when `rx_s`=1 is seen in IDLE and cleared on leaving IDLE. This means a line held low (break) produces at most one frame_err and never retriggers.
- **State machine:** IDLE, START, DATA, PARITY (macro only), STOP.
  - **IDLE:** when armed and `rx_s`=0, go to START. Clear the tick counter and the sample counter.
  - **START:** on tick number OVERSAMPLE/2, sample `rx_s`.
    - If 1: false start, return to IDLE with no error.
    - If 0: go to DATA and clear the sample counter.
  - **DATA:** every OVERSAMPLE ticks, sample `rx_s` into the shift register, LSB first. After bit 7, go to PARITY (macro) or STOP.
  - **PARITY:** after OVERSAMPLE ticks, sample the parity bit and compare it with even parity of the 8 data bits. Go to STOP.
  - **STOP:** after OVERSAMPLE ticks, sample `rx_s`.
    - 1: commit the byte.
    - 0: pulse `frame_err`, discard the byte.
    - In both cases go to IDLE.
- **Commit rules.** A commit is attempted on the cycle after the stop sample.
  - If `valid`=0, or `valid && ready` in that same cycle: load `data` and set `valid`=1.
  - Otherwise: keep the old `data` and `valid`, and pulse `overrun`.
- **Handshake.**
  - `valid` drops on the cycle after `valid && ready`, unless a commit happens in the same cycle.
  - `data` is stable while `valid`=1.
  - `ready` while `valid`=0 has no effect.
- **Parity error.** A parity mismatch pulses `parity_err` and discards the byte, with no commit. A bad stop bit takes precedence: only `frame_err` pulses.
- **Reset.** Reset mid-frame aborts the frame. State goes to IDLE with the armed flag cleared; no pulse is generated.

## Timing
- Reset values:
  - `data`=8'h00, `valid`=0, `busy`=0.
  - `frame_err`=0, `overrun`=0, `parity_err`=0.
  - All counters 0, synchroniser flops 1.
- Input latency: 2 cycles from `rx` to `rx_s`.
- Bit n is sampled (OVERSAMPLE/2 + (n+1)·OVERSAMPLE)·DIV cycles after the start edge reaches `rx_s`, where n = 0..7.
- `valid` rises 1 cycle after the stop-bit sample, which is 9.5 bit periods after the start edge (10.5 with parity).
- `busy` is high from the cycle after the start edge is detected through the stop-sample cycle.
- Error pulses are exactly 1 cycle wide and coincide with the would-be commit cycle.
- Back-to-back frames: a new start edge is accepted the first cycle after returning to IDLE with `rx_s`=0. A high stop bit keeps the armed flag set.

## Configuration
- Macro `UART_RX_PARITY_EN`.
- Defined: frames are 8E1. The PARITY state and the `parity_err` port exist, and parity mismatches are discarded as described above.
- Undefined: frames are 8N1. There is no PARITY state and no `parity_err` port.

## Test plan
All scenarios use CLK_FREQ=1_600_000, BAUD_RATE=10_000, OVERSAMPLE=16, so DIV=10 and one bit is 160 cycles.
- Send 8'hA5 as 8N1 with `ready`=1 → `valid` pulses for 1 cycle with `data`=8'hA5. No error pulses.
- Send 8'h3C then 8'hC3 back-to-back with `ready`=0 → first byte is held; `overrun` pulses once at the second commit; `data` stays 8'h3C. Then `ready`=1 → `valid` drops the next cycle.
- Hold the stop bit low for byte 8'h55 → `frame_err` pulses, `valid` stays 0. Hold the line low for 2000 cycles → no further pulses. Release it and send 8'h01 → received correctly.
- Drive a 40-cycle low glitch → false start; `busy` returns to 0 and nothing is reported.
- Assert `rst_n`=0 during bit 4 of 8'hFF, then send 8'h12 → only 8'h12 is delivered.
- With `UART_RX_PARITY_EN`: send 8'h07 with parity bit 1 → byte received. Send it with parity bit 0 → `parity_err` pulses and no `valid`.

Source files
------------

// File: rtl/uart_rx_oversample.sv
// Oversampling 8N1 UART receiver with a valid/ready byte output.
// Define UART_RX_PARITY_EN for 8E1 frames; this adds a parity check and the parity_err port.
module uart_rx_oversample #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       overrun,
    output logic       parity_err
`else
    output logic       overrun
`endif
);

    localparam int unsigned Div   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned TickW = (Div > 1) ? $clog2(Div) : 1;
    localparam int unsigned SampW = $clog2(OVERSAMPLE);

    localparam logic [TickW-1:0] TickLast = TickW'(Div - 1);
    localparam logic [SampW-1:0] HalfLast = SampW'(OVERSAMPLE / 2 - 1);
    localparam logic [SampW-1:0] FullLast = SampW'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} stateT;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} stateT;
`endif

    stateT            stateQ, stateD;
    logic             rxMetaQ, rxSQ;
    logic [TickW-1:0] tickCntQ, tickCntD;
    logic [SampW-1:0] sampCntQ, sampCntD;
    logic [2:0]       bitCntQ, bitCntD;
    logic [7:0]       shiftQ, shiftD;
    logic             armedQ, armedD;
    logic [7:0]       dataQ, dataD;
    logic             validQ, validD;
    logic             frameErrQ, frameErrD;
    logic             overrunQ, overrunD;
    logic             tick;
    logic             commit;
`ifdef UART_RX_PARITY_EN
    logic             parBadQ, parBadD;
    logic             parityErrQ, parityErrD;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxMetaQ   <= 1'b1;
            rxSQ      <= 1'b1;
            stateQ    <= StIdle;
            tickCntQ  <= '0;
            sampCntQ  <= '0;
            bitCntQ   <= '0;
            shiftQ    <= '0;
            armedQ    <= 1'b0;
            dataQ     <= 8'h00;
            validQ    <= 1'b0;
            frameErrQ <= 1'b0;
            overrunQ  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parBadQ    <= 1'b0;
            parityErrQ <= 1'b0;
`endif
        end else begin
            rxMetaQ   <= rx;
            rxSQ      <= rxMetaQ;
            stateQ    <= stateD;
            tickCntQ  <= tickCntD;
            sampCntQ  <= sampCntD;
            bitCntQ   <= bitCntD;
            shiftQ    <= shiftD;
            armedQ    <= armedD;
            dataQ     <= dataD;
            validQ    <= validD;
            frameErrQ <= frameErrD;
            overrunQ  <= overrunD;
`ifdef UART_RX_PARITY_EN
            parBadQ    <= parBadD;
            parityErrQ <= parityErrD;
`endif
        end
    end

    assign tick = (tickCntQ == TickLast);

    always_comb begin
        stateD    = stateQ;
        sampCntD  = sampCntQ;
        bitCntD   = bitCntQ;
        shiftD    = shiftQ;
        armedD    = armedQ;
        dataD     = dataQ;
        validD    = validQ;
        frameErrD = 1'b0;
        overrunD  = 1'b0;
        commit    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parBadD    = parBadQ;
        parityErrD = 1'b0;
`endif

        // Tick phase restarts from the start edge so samples land mid-bit.
        if (stateQ == StIdle) begin
            tickCntD = '0;
        end else if (tick) begin
            tickCntD = '0;
        end else begin
            tickCntD = tickCntQ + TickW'(1);
        end

        if (validQ && ready) begin
            validD = 1'b0;
        end

        case (stateQ)
            StIdle: begin
                sampCntD = '0;
                bitCntD  = '0;
                if (rxSQ) begin
                    armedD = 1'b1;
                end
                if (armedQ && !rxSQ) begin
                    stateD = StStart;
                    armedD = 1'b0;
                end
            end
            StStart: begin
                if (tick) begin
                    if (sampCntQ == HalfLast) begin
                        sampCntD = '0;
                        stateD   = rxSQ ? StIdle : StData;
                    end else begin
                        sampCntD = sampCntQ + SampW'(1);
                    end
                end
            end
            StData: begin
                if (tick) begin
                    if (sampCntQ == FullLast) begin
                        sampCntD = '0;
                        shiftD   = {rxSQ, shiftQ[7:1]};
                        bitCntD  = bitCntQ + 3'd1;
                        if (bitCntQ == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            stateD = StParity;
`else
                            stateD = StStop;
`endif
                        end
                    end else begin
                        sampCntD = sampCntQ + SampW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (tick) begin
                    if (sampCntQ == FullLast) begin
                        sampCntD = '0;
                        parBadD  = (rxSQ != ^shiftQ);
                        stateD   = StStop;
                    end else begin
                        sampCntD = sampCntQ + SampW'(1);
                    end
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    if (sampCntQ == FullLast) begin
                        sampCntD = '0;
                        stateD   = StIdle;
                        if (rxSQ) begin
                            // A high stop bit doubles as the idle level for the next frame.
                            armedD = 1'b1;
`ifdef UART_RX_PARITY_EN
                            if (parBadQ) begin
                                parityErrD = 1'b1;
                            end else begin
                                commit = 1'b1;
                            end
`else
                            commit = 1'b1;
`endif
                        end else begin
                            frameErrD = 1'b1;
                        end
                    end else begin
                        sampCntD = sampCntQ + SampW'(1);
                    end
                end
            end
            default: begin
                stateD = StIdle;
            end
        endcase

        if (commit) begin
            if (!validQ || ready) begin
                dataD  = shiftQ;
                validD = 1'b1;
            end else begin
                overrunD = 1'b1;
            end
        end
    end

    assign data      = dataQ;
    assign valid     = validQ;
    assign busy      = (stateQ != StIdle);
    assign frame_err = frameErrQ;
    assign overrun   = overrunQ;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parityErrQ;
`endif

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench for uart_rx_oversample: directed frames plus randomized bytes and ready.
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx_oversample;

    localparam int unsigned ClkFreq    = 1_600_000;
    localparam int unsigned BaudRate   = 10_000;
    localparam int unsigned Oversample = 16;
    localparam int unsigned Div        = ClkFreq / (BaudRate * Oversample);
    localparam int unsigned BitCycles  = Div * Oversample;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned StopIdx = 10;
`else
    localparam int unsigned StopIdx = 9;
`endif
    // Synchroniser, then the stop-sample offset from the start edge, then the commit register.
    localparam int unsigned Latency = 2 + (Oversample / 2 + StopIdx * Oversample) * Div + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       readyStim;
    logic       readyRnd = 1'b0;
    logic       randReady;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    logic [7:0]  expQ [$];
    int          feSeen = 0, ovSeen = 0, peSeen = 0;
    int          expFe = 0, expOv = 0, expPe = 0;
    int unsigned riseCyc = 0;
    int          runLen = 0, lastRunLen = 0;

    uart_rx_oversample #(
        .CLK_FREQ  (ClkFreq),
        .BAUD_RATE (BaudRate),
        .OVERSAMPLE(Oversample)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .overrun   (overrun),
        .parity_err(parity_err)
`else
        .overrun   (overrun)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign ready = randReady ? readyRnd : readyStim;

    always @(posedge clk) begin
        #1;
        readyRnd = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic waitCyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic stopVal, input logic parFlip);
        rx = 1'b0;
        waitCyc(BitCycles);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            waitCyc(BitCycles);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ parFlip;
        waitCyc(BitCycles);
`endif
        rx = stopVal;
        waitCyc(BitCycles);
    endtask

    task automatic checkCounts(input string tag);
        check({tag, " frame_err count"}, feSeen, expFe);
        check({tag, " overrun count"}, ovSeen, expOv);
`ifdef UART_RX_PARITY_EN
        check({tag, " parity_err count"}, peSeen, expPe);
`endif
    endtask

    task automatic monitor();
        logic       prevValid = 1'b0, prevAcc = 1'b0, prevFe = 1'b0, prevOv = 1'b0;
        logic       prevPe = 1'b0;
        logic [7:0] prevData = 8'h00;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prevValid = 1'b0;
                prevAcc   = 1'b0;
                prevFe    = 1'b0;
                prevOv    = 1'b0;
                prevPe    = 1'b0;
                runLen    = 0;
                continue;
            end
            if (frame_err) begin
                feSeen++;
                check("frame_err one cycle", prevFe, 1'b0);
            end
            if (overrun) begin
                ovSeen++;
                check("overrun one cycle", prevOv, 1'b0);
            end
`ifdef UART_RX_PARITY_EN
            if (parity_err) begin
                peSeen++;
                check("parity_err one cycle", prevPe, 1'b0);
            end
            prevPe = parity_err;
`endif
            if (valid && prevValid && !prevAcc) check("data held while valid", data, prevData);
            if (valid && !prevValid) riseCyc = cyc;
            if (valid) begin
                runLen++;
            end else if (prevValid) begin
                lastRunLen = runLen;
                runLen = 0;
            end
            if (valid && ready) begin
                check("byte was expected", expQ.size() != 0, 1'b1);
                if (expQ.size() != 0) begin
                    e = expQ.pop_front();
                    check("rx byte", data, e);
                end
            end
            prevValid = valid;
            prevAcc   = valid && ready;
            prevData  = data;
            prevFe    = frame_err;
            prevOv    = overrun;
        end
    endtask

    initial begin
        int unsigned startCyc;
        int          waited;
        logic [7:0]  b;

        rst_n     = 1'b0;
        rx        = 1'b1;
        readyStim = 1'b1;
        randReady = 1'b0;
        fork
            monitor();
        join_none
        waitCyc(5);
        check("reset data", data, 8'h00);
        check("reset valid", valid, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset frame_err", frame_err, 1'b0);
        check("reset overrun", overrun, 1'b0);
        rst_n = 1'b1;
        waitCyc(20);

        // Single byte with ready held high.
        expQ.push_back(8'hA5);
        startCyc = cyc;
        sendFrame(8'hA5, 1'b1, 1'b0);
        waitCyc(20);
        check("valid latency", riseCyc - startCyc, Latency);
        check("valid width", lastRunLen, 1);
        check("busy after frame", busy, 1'b0);
        checkCounts("single");

        // Back-to-back frames with no consumer: the second is dropped.
        readyStim = 1'b0;
        expQ.push_back(8'h3C);
        sendFrame(8'h3C, 1'b1, 1'b0);
        sendFrame(8'hC3, 1'b1, 1'b0);
        expOv++;
        waitCyc(10);
        check("held valid", valid, 1'b1);
        check("held data", data, 8'h3C);
        checkCounts("overrun");
        readyStim = 1'b1;
        waitCyc(1);
        check("valid drop after accept", valid, 1'b0);

        // Bad stop bit, then a long break.
        sendFrame(8'h55, 1'b0, 1'b0);
        expFe++;
        waitCyc(2000);
        check("valid after framing error", valid, 1'b0);
        check("busy during break", busy, 1'b0);
        checkCounts("break");
        rx = 1'b1;
        waitCyc(40);
        expQ.push_back(8'h01);
        sendFrame(8'h01, 1'b1, 1'b0);
        waitCyc(20);
        checkCounts("after break");

        // Short low glitch is rejected at the mid-start sample.
        rx = 1'b0;
        waitCyc(20);
        check("busy during glitch", busy, 1'b1);
        waitCyc(20);
        rx = 1'b1;
        waitCyc(BitCycles);
        check("busy after glitch", busy, 1'b0);
        check("valid after glitch", valid, 1'b0);
        checkCounts("glitch");

        // Reset during bit 4 of 8'hFF aborts it silently.
        rx = 1'b0;
        waitCyc(BitCycles);
        rx = 1'b1;
        waitCyc(4 * BitCycles + BitCycles / 2);
        rst_n = 1'b0;
        waitCyc(4);
        check("busy in reset", busy, 1'b0);
        check("data in reset", data, 8'h00);
        rst_n = 1'b1;
        waitCyc(4 * BitCycles);
        expQ.push_back(8'h12);
        sendFrame(8'h12, 1'b1, 1'b0);
        waitCyc(20);
        checkCounts("reset abort");

`ifdef UART_RX_PARITY_EN
        expQ.push_back(8'h07);
        sendFrame(8'h07, 1'b1, 1'b0);
        sendFrame(8'h07, 1'b1, 1'b1);
        expPe++;
        waitCyc(20);
        check("valid after parity error", valid, 1'b0);
        checkCounts("parity");
        sendFrame(8'h07, 1'b0, 1'b1);
        expFe++;
        rx = 1'b1;
        waitCyc(40);
        checkCounts("parity and stop");
`endif

        // Random bytes, random gaps, random ready.
        randReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 2) != 0) waitCyc(int'($urandom_range(1, 100)));
            expQ.push_back(b);
            sendFrame(b, 1'b1, 1'b0);
        end
        waited = 0;
        while (expQ.size() != 0 && waited < 5000) begin
            waitCyc(1);
            waited++;
        end
        check("all bytes delivered", expQ.size(), 0);
        checkCounts("random");
        randReady = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
